// File: rtl/out_pkg.sv
// Shared types and width helpers for the buffered output port (out_port_buffered, out_fifo).
package out_pkg;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_CHANNELS = 2;

  // Channel index width never drops below one bit, even for a single channel.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_CH_W  = ch_w(DEF_CHANNELS);
  localparam int DEF_CNT_W = cnt_w(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_DATA_W-1:0] data;
  } out_entry_t;

endpackage

// File: rtl/out_fifo.sv
// Generic synchronous show-ahead FIFO: head entry is readable combinationally whenever not empty.
module out_fifo
  import out_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int WIDTH = DEF_CH_W + DEF_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             push_ok,
  output logic             pop_ok,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok   = pop_req && !empty_q;
    push_ok  = push_req && (!full_q || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/out_port_buffered.sv
// Buffered, channel-tagged output port between the A register and display drivers.
// Define OUT_STALL_EN to back-pressure the sequencer instead of dropping pushes while full.
module out_port_buffered
  import out_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int CH_W     = ch_w(CHANNELS),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         la_out,
  input  logic [CH_W-1:0]              ch_sel,
  input  logic [DATA_W-1:0]            a_data,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [DATA_W-1:0]            disp_data,
  output logic [CH_W-1:0]              disp_ch,
  output logic [CHANNELS*DATA_W-1:0]   out_latched,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty,
  output logic                         stall,
  output logic                         overflow
);

  localparam int ENT_W = CH_W + DATA_W;

  // Handshake: an entry transfers on a rising edge where disp_valid && disp_ready;
  // disp_valid never depends on disp_ready, and the head holds steady until taken.
  logic [ENT_W-1:0]           push_entry;
  logic [ENT_W-1:0]           head_entry;
  logic                       push_ok;
  logic                       pop_ok;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CHANNELS*DATA_W-1:0] latch_q, latch_d;
  logic                       overflow_q, overflow_d;

  assign push_entry = {ch_sel, a_data};

  out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (la_out),
    .pop_req  (disp_ready),
    .din      (push_entry),
    .dout     (head_entry),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign disp_data  = head_entry[DATA_W-1:0];
  assign disp_ch    = head_entry[ENT_W-1:DATA_W];
  assign disp_valid = !fifo_empty;
  assign full       = fifo_full;
  assign empty      = fifo_empty;

  // Entries tagged with a nonexistent channel are popped but update no latch.
  always_comb begin
    latch_d = latch_q;
    if (pop_ok) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (disp_ch == CH_W'(k)) begin
          latch_d[k*DATA_W +: DATA_W] = disp_data;
        end
      end
    end
`ifdef OUT_STALL_EN
    overflow_d = overflow_q;
`else
    overflow_d = overflow_q | (la_out && !push_ok);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      latch_q    <= latch_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_latched = latch_q;
  assign overflow    = overflow_q;

`ifdef OUT_STALL_EN
  assign stall = fifo_full;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_buffered.sv
// Directed scoreboard bench for out_port_buffered (DATA_W=4, DEPTH=4, CHANNELS=3).
module tb_out_port_buffered;

  localparam int DATA_W   = 4;
  localparam int DEPTH    = 4;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 3;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       la_out;
  logic [CH_W-1:0]            ch_sel;
  logic [DATA_W-1:0]          a_data;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [DATA_W-1:0]          disp_data;
  logic [CH_W-1:0]            disp_ch;
  logic [CHANNELS*DATA_W-1:0] out_latched;
  logic [CNT_W-1:0]           count;
  logic                       full;
  logic                       empty;
  logic                       stall;
  logic                       overflow;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  out_port_buffered #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .la_out      (la_out),
    .ch_sel      (ch_sel),
    .a_data      (a_data),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_data   (disp_data),
    .disp_ch     (disp_ch),
    .out_latched (out_latched),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .stall       (stall),
    .overflow    (overflow)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [CH_W+DATA_W-1:0] exp_q[$];
  logic [CH_W+DATA_W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d, input bit accept);
    la_out = 1'b1;
    ch_sel = ch;
    a_data = d;
    if (accept) exp_q.push_back({ch, d});
    tick(1);
    la_out = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while (!empty && k < 50) begin
      tick(1);
      k++;
    end
    check(name, {31'b0, empty}, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && disp_valid && disp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got ch %0h data %0h expected none", disp_ch, disp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_data", {28'b0, disp_data}, {28'b0, mon_e[DATA_W-1:0]});
        check("pop_ch", {30'b0, disp_ch}, {30'b0, mon_e[CH_W+DATA_W-1:DATA_W]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; la_out = 1'b0; ch_sel = '0; a_data = '0; disp_ready = 1'b0;
    tick(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_ovf", overflow, 0);
    check("rst_latch", out_latched, 0);
    check("rst_data", disp_data, 0);
    reset = 1'b0;

    // basic pass-through to ch0 and ch1
    disp_ready = 1'b1;
    push(2'd0, 4'h1, 1'b1);
    push(2'd1, 4'h8, 1'b1);
    wait_empty("t1_drain");
    check("t1_latch", out_latched, 12'h081);
    check("t1_count", count, 0);

    // fill with display stalled
    disp_ready = 1'b0;
    push(2'd2, 4'h3, 1'b1);
    push(2'd2, 4'h5, 1'b1);
    push(2'd2, 4'h7, 1'b1);
    push(2'd2, 4'h9, 1'b1);
    check("t2_full", full, 1);
    check("t2_count", count, 4);
    check("t2_valid", disp_valid, 1);
    check("t2_head", disp_data, 4'h3);
    tick(2);
    check("t2_hold", disp_data, 4'h3);

    // fifth push while full
`ifdef OUT_STALL_EN
    check("t3_stall_pre", stall, 1);
    push(2'd2, 4'hA, 1'b0);
    check("t3_stall", stall, 1);
    check("t3_ovf", overflow, 0);
    check("t3_count", count, 4);
    la_out = 1'b1; ch_sel = 2'd2; a_data = 4'hA; disp_ready = 1'b1;
    exp_q.push_back({2'd2, 4'hA});
    tick(1);
    la_out = 1'b0;
    check("t3_retry_count", count, 4);
`else
    push(2'd2, 4'hA, 1'b0);
    check("t3_stall", stall, 0);
    check("t3_ovf", overflow, 1);
    check("t3_count", count, 4);
    disp_ready = 1'b1;
`endif
    wait_empty("t3_drain");
`ifdef OUT_STALL_EN
    check("t3_latch", out_latched, 12'hA81);
`else
    check("t3_latch", out_latched, 12'h981);
`endif

    // full with simultaneous push and pop
    disp_ready = 1'b0;
    push(2'd0, 4'h1, 1'b1);
    push(2'd0, 4'h2, 1'b1);
    push(2'd0, 4'h3, 1'b1);
    push(2'd0, 4'h4, 1'b1);
    check("t4_full_pre", full, 1);
    la_out = 1'b1; ch_sel = 2'd0; a_data = 4'hC; disp_ready = 1'b1;
    exp_q.push_back({2'd0, 4'hC});
    tick(1);
    la_out = 1'b0; disp_ready = 1'b0;
    check("t4_count", count, 4);
    check("t4_full", full, 1);
    check("t4_head", disp_data, 4'h2);
    disp_ready = 1'b1;
    wait_empty("t4_drain");
`ifdef OUT_STALL_EN
    check("t4_latch", out_latched, 12'hA8C);
`else
    check("t4_latch", out_latched, 12'h98C);
`endif

    // nonexistent channel 3 is popped without touching latches
    push(2'd3, 4'hF, 1'b1);
    wait_empty("t5_drain");
`ifdef OUT_STALL_EN
    check("t5_latch", out_latched, 12'hA8C);
`else
    check("t5_latch", out_latched, 12'h98C);
`endif
    check("t5_count", count, 0);

    // reset in the middle of a drain
    disp_ready = 1'b0;
    push(2'd1, 4'h6, 1'b1);
    push(2'd1, 4'h7, 1'b1);
    push(2'd2, 4'h5, 1'b1);
    disp_ready = 1'b1;
    tick(1);
    check("t6_count_mid", count, 2);
`ifdef OUT_STALL_EN
    check("t6_latch_mid", out_latched, 12'hA6C);
`else
    check("t6_latch_mid", out_latched, 12'h96C);
`endif
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_valid", disp_valid, 0);
    check("t6_latch", out_latched, 0);
    check("t6_ovf", overflow, 0);
    check("t6_stall", stall, 0);
    check("t6_data", disp_data, 0);
    check("t6_ch", disp_ch, 0);
    reset = 1'b0;
    disp_ready = 1'b0;
    tick(2);

    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
